moving_average3_inverse: RTL



---
 rtl/moving_average3_inverse_pkg.sv | 30 +++
 rtl/moving_average3_inverse_sat_sub3.sv | 45 ++++
 rtl/moving_average3_inverse.sv | 98 +++++++++
 3 files changed

// File: rtl/moving_average3_inverse_pkg.sv
// Shared types and constants for the 3-tap moving-sum decoder.
// The default link configuration is a 10-bit signed sum carrying 8-bit
// signed samples. The top and sub-module stay width-parameterised; these
// types describe that default configuration.
package moving_average3_inverse_types;

  localparam int SUM_W    = 10;
  localparam int SAMPLE_W = 8;

  typedef logic signed [SUM_W-1:0]    sum_t;
  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // History window: [0] = x[n-1], [1] = x[n-2].
  typedef sample_t [1:0] hist_t;

  localparam sample_t SAMPLE_MAX = sample_t'(127);
  localparam sample_t SAMPLE_MIN = sample_t'(-128);

  // Output register occupancy.
  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // Plain bit-vector view of a sample, for buses that carry raw bits.
  function automatic logic [SAMPLE_W-1:0] sample_to_slv(input sample_t v);
    return v;
  endfunction

endpackage

// File: rtl/moving_average3_inverse_sat_sub3.sv
// Combinational y = sat(s - a - b).
// Ports:
//   s   : signed SW-bit minuend (moving sum)
//   a,b : signed XW-bit subtrahends (history samples)
//   y   : result saturated to the signed XW-bit range
//   ovf : 1 when saturation was applied
// The difference is formed in SW+1 bits. With SW >= XW+2 the largest
// magnitude |s| + 2*2^(XW-1) stays below 2^SW, so it never wraps.
module sat_sub3
  import moving_average3_inverse_types::*;
#(
  parameter int SW = SUM_W,
  parameter int XW = SAMPLE_W
) (
  input  logic [SW-1:0] s,
  input  logic [XW-1:0] a,
  input  logic [XW-1:0] b,
  output logic [XW-1:0] y,
  output logic          ovf
);

  localparam int MAXV = (1 << (XW-1)) - 1;
  localparam logic signed [SW:0] DMAX = (SW+1)'(MAXV);
  // The bitwise inverse of +max is the two's-complement minimum, -max-1.
  localparam logic signed [SW:0] DMIN = ~DMAX;

  logic signed [SW:0] se, ae, be, d;

  always_comb begin
    se = {s[SW-1], s};
    ae = {{(SW+1-XW){a[XW-1]}}, a};
    be = {{(SW+1-XW){b[XW-1]}}, b};
    d  = se - ae - be;
    y   = d[XW-1:0];
    ovf = 1'b0;
    if (d > DMAX) begin
      y   = DMAX[XW-1:0];
      ovf = 1'b1;
    end else if (d < DMIN) begin
      y   = DMIN[XW-1:0];
      ovf = 1'b1;
    end
  end

endmodule

// File: rtl/moving_average3_inverse.sv
// Decoder for a 3-tap moving-sum stream: s[n] = x[n] + x[n-1] + x[n-2].
// Reconstructs x[n] = sat(s[n] - x[n-1] - x[n-2]) into a single registered
// output stage with valid/ready on both sides.
// Ports:
//   system1000       : clock
//   system1000_rstn  : synchronous active-low reset
//   s_valid/s_ready/s_data : input sum stream (signed SW bits)
//   resync           : zero the history (stream restart)
//   x_valid/x_ready/x_data : reconstructed sample stream (signed XW bits)
//   err              : sticky, set when a result had to be saturated
//   err_clr          : clears err (a same-cycle set wins)
module moving_average3_inverse
  import moving_average3_inverse_types::*;
#(
  parameter int SW = SUM_W,
  parameter int XW = SAMPLE_W
) (
  input  logic          system1000,
  input  logic          system1000_rstn,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [SW-1:0] s_data,
  input  logic          resync,
  output logic          x_valid,
  input  logic          x_ready,
  output logic [XW-1:0] x_data,
  output logic          err,
  input  logic          err_clr
);

  out_state_e    state, state_nxt;
  logic [XW-1:0] x_q;
  logic [XW-1:0] h1_q, h2_q;     // x[n-1], x[n-2]
  logic [XW-1:0] h1_eff, h2_eff;
  logic [XW-1:0] y;
  logic          ovf;
  logic          err_q;
  logic          in_xfer, out_xfer;

  assign x_valid  = (state == OUT_FULL);
  // Ready depends only on the output register, never on s_data.
  assign s_ready  = !x_valid || x_ready;
  assign in_xfer  = s_valid && s_ready;
  assign out_xfer = x_valid && x_ready;
  assign x_data   = x_q;
  assign err      = err_q;

  // resync makes a same-cycle sum decode against a zero window.
  assign h1_eff = resync ? '0 : h1_q;
  assign h2_eff = resync ? '0 : h2_q;

  sat_sub3 #(.SW(SW), .XW(XW)) u_sub (
    .s   (s_data),
    .a   (h1_eff),
    .b   (h2_eff),
    .y   (y),
    .ovf (ovf)
  );

  // Output occupancy FSM.
  always_ff @(posedge system1000) begin
    if (!system1000_rstn) state <= OUT_EMPTY;
    else                  state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      OUT_EMPTY: if (in_xfer) state_nxt = OUT_FULL;
      OUT_FULL:  if (out_xfer && !in_xfer) state_nxt = OUT_EMPTY;
      default:   state_nxt = OUT_EMPTY;
    endcase
  end

  // Data, history and sticky error.
  always_ff @(posedge system1000) begin
    if (!system1000_rstn) begin
      x_q   <= '0;
      h1_q  <= '0;
      h2_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (in_xfer) begin
        // The saturated value enters the window so decoding stays defined
        // after an illegal sum.
        x_q  <= y;
        h1_q <= y;
        h2_q <= h1_eff;
      end else if (resync) begin
        h1_q <= '0;
        h2_q <= '0;
      end
      if (in_xfer && ovf) err_q <= 1'b1;
      else if (err_clr)   err_q <= 1'b0;
    end
  end

endmodule
